hw_config_bank: RTL and testbench

- Parametrised successor to the constant hardware-config registers at the top of IO space.
- Keeps the RAM, DEVICES and CPUINFO constants and adds live registers:
  - a wide cycle counter of COUNTER_WIDTH bits, read coherently through a 32-bit LO/HI pair
  - a millisecond uptime counter
  - a scratch register
- Sits on the one-hot IO select lines. Read data is registered and zero when idle, so it can be OR-combined with the other IO devices' read data.

---
 rtl/hw_config_bank_if.sv | 28 ++
 rtl/hw_config_bank.sv | 82 ++++++++
 tb/tb_hw_config_bank.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/hw_config_bank_if.sv
// IO-select bus between the CPU IO decoder and the hardware-config bank.
// One-hot selects plus single-cycle rd/wr strobes; read data comes back registered.
interface hw_config_bank_if;
   logic        sel_memory;
   logic        sel_devices;
   logic        sel_cpuinfo;
   logic        sel_cycles_lo;
   logic        sel_cycles_hi;
   logic        sel_uptime;
   logic        sel_scratch;
   logic        rd;
   logic        wr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rdata_valid;

   modport master (
      output sel_memory, sel_devices, sel_cpuinfo, sel_cycles_lo, sel_cycles_hi,
             sel_uptime, sel_scratch, rd, wr, wdata,
      input  rdata, rdata_valid
   );

   modport slave (
      input  sel_memory, sel_devices, sel_cpuinfo, sel_cycles_lo, sel_cycles_hi,
             sel_uptime, sel_scratch, rd, wr, wdata,
      output rdata, rdata_valid
   );
endinterface

// File: rtl/hw_config_bank.sv
// Hardware-config register bank: RAM/DEVICES/CPUINFO constants plus a wide cycle
// counter (coherent LO/HI read), a millisecond uptime counter and a scratch register.
module hw_config_bank #(
   parameter int unsigned RAM_BYTES     = 6144,
   parameter logic [31:0] DEVICES       = 32'h0010_0007,
   parameter int unsigned FREQ_MHZ      = 50,
   parameter int unsigned COUNTER_WIDTH = 24
) (
   input logic             clk,
   input logic             reset,
   hw_config_bank_if.slave bus
);
   // hi_shadow keeps one dummy bit when the counter fits in 32 bits; it is never set then.
   localparam int unsigned HW      = (COUNTER_WIDTH > 32) ? COUNTER_WIDTH - 32 : 1;
   localparam logic [19:0] PRE_MAX = 20'(FREQ_MHZ * 1000 - 1);
   localparam logic [31:0] CPUINFO = (32'(FREQ_MHZ) << 16) | 32'(COUNTER_WIDTH);

   logic [COUNTER_WIDTH-1:0] counter;
   logic [HW-1:0]            hi_shadow;
   logic [19:0]              prescaler;
   logic [31:0]              uptime;
   logic [31:0]              scratch;
   logic [31:0]              rval;
   logic [63:0]              cnt_ext;
   logic [HW+31:0]           load_val;
   logic [6:0]               sel_raw;
   logic [6:0]               s;

   assign sel_raw = {bus.sel_scratch, bus.sel_uptime, bus.sel_cycles_hi, bus.sel_cycles_lo,
                     bus.sel_cpuinfo, bus.sel_devices, bus.sel_memory};
   // Isolate the lowest set bit: memory has the highest priority.
   assign s        = sel_raw & (~sel_raw + 7'd1);
   assign cnt_ext  = 64'(counter);
   assign load_val = {hi_shadow, bus.wdata};

   assign rval = ({32{s[0]}} & 32'(RAM_BYTES))
               | ({32{s[1]}} & DEVICES)
               | ({32{s[2]}} & CPUINFO)
               | ({32{s[3]}} & cnt_ext[31:0])
               | ({32{s[4]}} & 32'(hi_shadow))
               | ({32{s[5]}} & uptime)
               | ({32{s[6]}} & scratch);

   always_ff @(posedge clk) begin
      if (reset) begin
         counter         <= '0;
         hi_shadow       <= '0;
         prescaler       <= '0;
         uptime          <= '0;
         scratch         <= '0;
         bus.rdata       <= '0;
         bus.rdata_valid <= 1'b0;
      end else begin
         bus.rdata       <= bus.rd ? rval : '0;
         bus.rdata_valid <= bus.rd;

         if (bus.wr && s[3])
            counter <= load_val[COUNTER_WIDTH-1:0];
         else
            counter <= counter + COUNTER_WIDTH'(1);

         // LO read snapshots the upper bits so a later HI read is coherent.
         if (bus.rd && s[3])
            hi_shadow <= cnt_ext[32 +: HW];
         else if (bus.wr && s[4] && (COUNTER_WIDTH > 32))
            hi_shadow <= bus.wdata[HW-1:0];

         if (bus.wr && s[5]) begin
            prescaler <= '0;
            uptime    <= bus.wdata;
         end else if (prescaler == PRE_MAX) begin
            prescaler <= '0;
            uptime    <= uptime + 32'd1;
         end else begin
            prescaler <= prescaler + 20'd1;
         end

         if (bus.wr && s[6])
            scratch <= bus.wdata;
      end
   end
endmodule

// File: tb/tb_hw_config_bank.sv
// Random plus directed check of hw_config_bank in four parameterisations, against a
// model that derives counter/uptime from elapsed cycles since the last load.
module tb_hw_config_bank;
   localparam int NCFG = 4;
   localparam int CW_T [NCFG] = '{24, 8, 40, 64};
   localparam int FQ_T [NCFG] = '{50, 50, 1, 1023};

   logic        clk;
   logic        rst;
   logic [6:0]  sel;
   logic        rd, wr;
   logic [31:0] wdata;

   logic [31:0] rd_out [NCFG];
   logic        vo     [NCFG];

   logic [63:0] m_base [NCFG];
   logic [63:0] m_cyc  [NCFG];
   logic [31:0] m_hi   [NCFG];
   logic [31:0] m_upb  [NCFG];
   logic [63:0] m_upc  [NCFG];
   logic [31:0] m_scr  [NCFG];
   logic [31:0] m_exp  [NCFG];
   logic        m_ev   [NCFG];

   int nvec = 0;
   int nerr = 0;
   bit armed = 0;

   for (genvar k = 0; k < NCFG; k++) begin : g
      hw_config_bank_if ifc ();
      assign ifc.sel_memory    = sel[0];
      assign ifc.sel_devices   = sel[1];
      assign ifc.sel_cpuinfo   = sel[2];
      assign ifc.sel_cycles_lo = sel[3];
      assign ifc.sel_cycles_hi = sel[4];
      assign ifc.sel_uptime    = sel[5];
      assign ifc.sel_scratch   = sel[6];
      assign ifc.rd            = rd;
      assign ifc.wr            = wr;
      assign ifc.wdata         = wdata;
      assign rd_out[k]         = ifc.rdata;
      assign vo[k]             = ifc.rdata_valid;

      hw_config_bank #(.FREQ_MHZ(FQ_T[k]), .COUNTER_WIDTH(CW_T[k])) u_dut (
         .clk   (clk),
         .reset (rst),
         .bus   (ifc.slave)
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: counter = base + cycles since load, uptime = base + cycles since load / (MHz*1000).
   always @(posedge clk) begin
      for (int k = 0; k < NCFG; k++) begin
         logic [63:0] mask, cnt;
         logic [31:0] hmask, up, val;
         int          w;
         mask  = (CW_T[k] == 64) ? '1 : ((64'd1 << CW_T[k]) - 64'd1);
         hmask = mask[63:32];
         cnt   = (m_base[k] + m_cyc[k]) & mask;
         up    = m_upb[k] + 32'(m_upc[k] / 64'(FQ_T[k] * 1000));
         w = 7;
         for (int i = 6; i >= 0; i--) if (sel[i]) w = i;
         case (w)
            0:       val = 32'd6144;
            1:       val = 32'h0010_0007;
            2:       val = (32'(FQ_T[k]) << 16) | 32'(CW_T[k]);
            3:       val = cnt[31:0];
            4:       val = m_hi[k];
            5:       val = up;
            6:       val = m_scr[k];
            default: val = '0;
         endcase
         if (rst) begin
            m_base[k] <= '0; m_cyc[k] <= '0; m_hi[k] <= '0; m_upb[k] <= '0;
            m_upc[k]  <= '0; m_scr[k] <= '0; m_exp[k] <= '0; m_ev[k] <= 1'b0;
         end else begin
            m_ev[k]  <= rd;
            m_exp[k] <= rd ? val : '0;
            if (rd && w == 3)      m_hi[k] <= cnt[63:32];
            else if (wr && w == 4) m_hi[k] <= wdata & hmask;
            if (wr && w == 3) begin
               m_base[k] <= {m_hi[k], wdata} & mask;
               m_cyc[k]  <= '0;
            end else begin
               m_cyc[k] <= m_cyc[k] + 64'd1;
            end
            if (wr && w == 5) begin
               m_upb[k] <= wdata;
               m_upc[k] <= '0;
            end else begin
               m_upc[k] <= m_upc[k] + 64'd1;
            end
            if (wr && w == 6) m_scr[k] <= wdata;
         end
      end
   end

   // Advance one cycle and compare every configuration against the model.
   task automatic tick();
      @(negedge clk);
      if (armed) begin
         for (int k = 0; k < NCFG; k++) begin
            nvec++;
            if (rd_out[k] !== m_exp[k] || vo[k] !== m_ev[k]) begin
               nerr++;
               $display("FAIL model cfg%0d t=%0t: dut=%h/%b model=%h/%b",
                        k, $time, rd_out[k], vo[k], m_exp[k], m_ev[k]);
            end
         end
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic idle();
      sel = '0; rd = 1'b0; wr = 1'b0;
   endtask

   task automatic acc(input int idx, input bit r, input bit w, input logic [31:0] d);
      sel = 7'd1 << idx; rd = r; wr = w; wdata = d;
      tick();
      idle();
   endtask

   task automatic chk(input string name, input int k, input logic [31:0] exp, input logic ev = 1'b1);
      nvec++;
      if (rd_out[k] !== exp || vo[k] !== ev || m_exp[k] !== exp || m_ev[k] !== ev) begin
         nerr++;
         $display("FAIL %s cfg%0d: dut=%h/%b model=%h/%b required=%h/%b",
                  name, k, rd_out[k], vo[k], m_exp[k], m_ev[k], exp, ev);
      end
   endtask

   initial begin
      rst = 1'b1; wdata = '0; idle();
      tick(); tick();
      armed = 1;
      chk("reset", 0, 32'h0, 1'b0);
      chk("reset", 2, 32'h0, 1'b0);

      // Counter: read when it holds 9, then 256 cycles later.
      rst = 1'b0;
      ticks(9);
      acc(3, 1, 0, 0);
      chk("lo_9", 1, 32'd9);
      chk("lo_9", 0, 32'd9);
      ticks(255);
      acc(3, 1, 0, 0);
      chk("lo_wrap", 1, 32'd9);
      chk("lo_265", 0, 32'd265);
      acc(4, 1, 0, 0);
      chk("hi_narrow", 1, 32'd0);
      tick();
      chk("idle", 0, 32'd0, 1'b0);

      // Constants.
      acc(0, 1, 0, 0); chk("memory", 0, 32'd6144);
      acc(1, 1, 0, 0); chk("devices", 0, 32'h0010_0007);
      acc(2, 1, 0, 0); chk("cpuinfo", 0, 32'h0032_0018);
      chk("cpuinfo", 2, 32'h0001_0028);
      tick();
      chk("idle", 0, 32'd0, 1'b0);

      // Coherent wide read.
      acc(4, 0, 1, 32'h12);
      acc(3, 0, 1, 32'hFFFF_FFF0);
      ticks(19);
      acc(3, 1, 0, 0);
      chk("coh_lo", 2, 32'h3);
      chk("coh_lo", 3, 32'h3);
      ticks(5);
      acc(4, 1, 0, 0);
      chk("coh_hi", 2, 32'h13);
      chk("coh_hi", 3, 32'h13);
      ticks(1000);
      acc(4, 1, 0, 0);
      chk("coh_hi_late", 2, 32'h13);

      // Uptime from reset, then wrap after preload.
      rst = 1'b1; tick(); rst = 1'b0;
      ticks(2500);
      acc(5, 1, 0, 0);
      chk("uptime_2500", 2, 32'd2);
      acc(5, 0, 1, 32'hFFFF_FFFF);
      ticks(1000);
      acc(5, 1, 0, 0);
      chk("uptime_wrap", 2, 32'd0);

      // Scratch, read-only writes, rd+wr ordering, select priority.
      acc(6, 0, 1, 32'hA5A5_5A5A);
      acc(0, 0, 1, 32'h0);
      acc(0, 1, 0, 0);         chk("memory_ro", 0, 32'd6144);
      acc(6, 1, 1, 32'h1);     chk("scratch_rdwr", 0, 32'hA5A5_5A5A);
      acc(6, 1, 0, 0);         chk("scratch_new", 0, 32'h1);
      sel = 7'b100_0010; rd = 1'b1; tick(); idle();
      chk("dual_sel", 0, 32'h0010_0007);

      // Reset dominates a read in the same cycle; counter restarts at 0.
      sel = 7'd1 << 3; rd = 1'b1; rst = 1'b1; tick(); idle();
      chk("reset_rd", 0, 32'd0, 1'b0);
      rst = 1'b0; sel = 7'd1 << 3; rd = 1'b1; tick(); idle();
      chk("reset_restart", 0, 32'd0, 1'b1);
      chk("reset_restart", 3, 32'd0, 1'b1);

      // Random traffic.
      repeat (3000) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 7)       sel = 7'd1 << r;
         else if (r == 7) sel = '0;
         else             sel = 7'($urandom);
         rd    = 1'($urandom);
         wr    = ($urandom % 3) == 0;
         wdata = ($urandom % 4 == 0) ? (32'hFFFF_FFC0 | 32'($urandom % 64)) : $urandom;
         rst   = ($urandom % 250) == 0;
         tick();
      end
      rst = 1'b0; idle();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
